alu_serial_rx: RTL and testbench

Serial command receiver sitting directly upstream of the ALU core. It samples the single-wire `sin` stream one bit per clock and assembles 11-bit packets into operand words. It checks the command CRC and operation code (`operation_t` from `alu_pkg`). For each command it delivers either operands A, B and op with a one-cycle valid pulse, or a one-cycle error pulse with error flags, for the core and response serializer.

---
 rtl/alu_serial_rx.sv | 176 +++++++++++++++++
 tb/tb_alu_serial_rx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_rx.sv
// alu_serial_rx: single-wire command receiver in front of the ALU core.
// Collects 11-bit packets (start, type, 8 payload bits MSB first, stop),
// assembles eight DATA bytes into operands B then A, and on the closing CTL
// packet checks byte count, CRC-4 and opcode before presenting one command.
module alu_serial_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [2:0]  op_o,
  output logic        valid_o,
  output logic        err_o,
  output logic [2:0]  err_flags_o
);

  // Opcodes the core accepts (operation_t encoding).
  localparam logic [2:0] AND_OP = 3'b000;
  localparam logic [2:0] OR_OP  = 3'b001;
  localparam logic [2:0] ADD_OP = 3'b100;
  localparam logic [2:0] SUB_OP = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TYPE    = 3'd1,
    S_PAYLOAD = 3'd2,
    S_STOP    = 3'd3,
    S_RESYNC  = 3'd4
  } state_t;

  state_t      state_q,    state_d;
  logic        type_q,     type_d;
  logic [2:0]  bit_cnt_q,  bit_cnt_d;
  logic [7:0]  payload_q,  payload_d;
  logic [3:0]  data_cnt_q, data_cnt_d;
  logic [63:0] byte_buf_q, byte_buf_d;
  logic [31:0] a_q,        a_d;
  logic [31:0] b_q,        b_d;
  logic [2:0]  op_q,       op_d;
  logic        valid_q,    valid_d;
  logic        err_q,      err_d;
  logic [2:0]  flags_q,    flags_d;

  // CRC-4, x^4+x+1, init 0, MSB first, shifted one message bit at a time.
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  logic [2:0] ctl_op;
  logic [3:0] ctl_crc;
  logic       crc_ok;
  logic       op_ok;

  assign ctl_op  = payload_q[6:4];
  assign ctl_crc = payload_q[3:0];
  assign crc_ok  = (crc4({byte_buf_q, 1'b1, ctl_op}) == ctl_crc);
  assign op_ok   = (ctl_op == AND_OP) || (ctl_op == OR_OP) ||
                   (ctl_op == ADD_OP) || (ctl_op == SUB_OP);

  // State register: every flop of the receiver, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      type_q     <= 1'b0;
      bit_cnt_q  <= 3'd0;
      payload_q  <= 8'd0;
      data_cnt_q <= 4'd0;
      byte_buf_q <= 64'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      op_q       <= 3'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      flags_q    <= 3'd0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      bit_cnt_q  <= bit_cnt_d;
      payload_q  <= payload_d;
      data_cnt_q <= data_cnt_d;
      byte_buf_q <= byte_buf_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      flags_q    <= flags_d;
    end
  end

  // Next-state logic: packet framing plus the per-packet shift/bit counter.
  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    bit_cnt_d = bit_cnt_q;
    payload_d = payload_q;
    unique case (state_q)
      S_IDLE: begin
        if (!sin) state_d = S_TYPE;
      end
      S_TYPE: begin
        type_d    = sin;
        bit_cnt_d = 3'd0;
        state_d   = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        payload_d = {payload_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: begin
        // A good stop bit returns straight to IDLE so a start bit may follow
        // with no idle gap; a bad one waits for the line to go high first.
        state_d = sin ? S_IDLE : S_RESYNC;
      end
      S_RESYNC: begin
        if (sin) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: byte collection, command evaluation and the result pulses.
  always_comb begin
    data_cnt_d = data_cnt_q;
    byte_buf_d = byte_buf_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    flags_d    = 3'b000;
    if (state_q == S_STOP) begin
      if (!sin) begin
        // Framing error: the partial command is abandoned.
        err_d      = 1'b1;
        flags_d    = 3'b100;
        data_cnt_d = 4'd0;
      end else if (!type_q) begin
        // Only the first eight bytes are kept; the counter stops at 9 so an
        // overlong command still reads as "not eight".
        if (data_cnt_q < 4'd8) byte_buf_d = {byte_buf_q[55:0], payload_q};
        if (data_cnt_q != 4'd9) data_cnt_d = data_cnt_q + 4'd1;
      end else begin
        data_cnt_d = 4'd0;
        if (data_cnt_q != 4'd8) begin
          err_d   = 1'b1;
          flags_d = 3'b100;
        end else if (!crc_ok || !op_ok) begin
          err_d   = 1'b1;
          flags_d = {1'b0, !crc_ok, !op_ok};
        end else begin
          b_d     = byte_buf_q[63:32];
          a_d     = byte_buf_q[31:0];
          op_d    = ctl_op;
          valid_d = 1'b1;
        end
      end
    end
  end

  assign a_o         = a_q;
  assign b_o         = b_q;
  assign op_o        = op_q;
  assign valid_o     = valid_q;
  assign err_o       = err_q;
  assign err_flags_o = flags_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// Bench for alu_serial_rx: directed cases plus randomized commands. Driver
// tasks update a command-level reference model and push expected results;
// a monitor pops and compares whenever the DUT pulses valid_o or err_o.
module tb_alu_serial_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic [31:0] a_o;
  logic [31:0] b_o;
  logic [2:0]  op_o;
  logic        valid_o;
  logic        err_o;
  logic [2:0]  err_flags_o;

  alu_serial_rx dut (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .a_o         (a_o),
    .b_o         (b_o),
    .op_o        (op_o),
    .valid_o     (valid_o),
    .err_o       (err_o),
    .err_flags_o (err_flags_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [2:0]  flags;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  cmd_bytes[$];
  logic [31:0] held_a  = 32'd0;
  logic [31:0] held_b  = 32'd0;
  logic [2:0]  held_op = 3'd0;
  int          tests   = 0;
  int          fails   = 0;
  logic        prev_pulse = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC as polynomial long division of {msg, 0000} by 10011.
  function automatic logic [3:0] ref_crc(input logic [67:0] msg);
    logic [71:0] r;
    r = {msg, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [3:0] good_crc(input logic [31:0] b, input logic [31:0] a,
                                          input logic [2:0] op);
    return ref_crc({b, a, 1'b1, op});
  endfunction

  function automatic logic legal_op(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101);
  endfunction

  task automatic push_exp(input logic is_err, input logic [2:0] flags);
    exp_t e;
    e.is_err = is_err;
    e.flags  = flags;
    e.a      = held_a;
    e.b      = held_b;
    e.op     = held_op;
    sb_q.push_back(e);
  endtask

  // Command-level model: called once per completed packet.
  task automatic model_packet(input logic typ, input logic [7:0] pl, input logic stop_bit);
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    logic        crc_bad;
    logic        op_bad;
    if (!stop_bit) begin
      push_exp(1'b1, 3'b100);
      cmd_bytes.delete();
    end else if (!typ) begin
      cmd_bytes.push_back(pl);
    end else begin
      if (cmd_bytes.size() != 8) begin
        push_exp(1'b1, 3'b100);
      end else begin
        b  = {cmd_bytes[0], cmd_bytes[1], cmd_bytes[2], cmd_bytes[3]};
        a  = {cmd_bytes[4], cmd_bytes[5], cmd_bytes[6], cmd_bytes[7]};
        op = pl[6:4];
        crc_bad = (good_crc(b, a, op) != pl[3:0]);
        op_bad  = !legal_op(op);
        if (crc_bad || op_bad) begin
          push_exp(1'b1, {1'b0, crc_bad, op_bad});
        end else begin
          held_a  = a;
          held_b  = b;
          held_op = op;
          push_exp(1'b0, 3'b000);
        end
      end
      cmd_bytes.delete();
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_packet(input logic typ, input logic [7:0] pl, input logic stop_bit);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(pl[i]);
    send_bit(stop_bit);
    model_packet(typ, pl, stop_bit);
  endtask

  task automatic send_cmd(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                          input logic [3:0] crc, input int nbytes, input int max_gap);
    logic [63:0] ba;
    logic [7:0]  by;
    logic        b7;
    ba = {b, a};
    for (int i = 0; i < nbytes; i++) begin
      if (i < 8) by = ba[63-8*i -: 8];
      else       by = 8'($urandom);
      send_packet(1'b0, by, 1'b1);
      idle(int'($urandom_range(max_gap, 0)));
    end
    b7 = 1'($urandom);
    send_packet(1'b1, {b7, op, crc}, 1'b1);
    idle(int'($urandom_range(max_gap, 0)));
  endtask

  // Monitor: compares each result pulse with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (valid_o && err_o) begin
        tests++;
        fails++;
        $display("[TB] FAIL both_pulses: got valid=1 err=1 expected at most one");
      end
      if (!err_o && err_flags_o != 3'b000) begin
        tests++;
        fails++;
        $display("[TB] FAIL idle_flags: got %b expected 000", err_flags_o);
      end
      if (valid_o || err_o) begin
        if (prev_pulse) begin
          tests++;
          fails++;
          $display("[TB] FAIL pulse_width: got pulse longer than 1 cycle expected 1");
        end
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_pulse: got valid=%b err=%b expected none", valid_o, err_o);
        end else begin
          e = sb_q.pop_front();
          $display("[TB] rx %s flags=%b a=%h b=%h op=%b", valid_o ? "valid " : "reject",
                   err_flags_o, a_o, b_o, op_o);
          check("pulse_kind", {62'd0, valid_o, err_o}, {62'd0, !e.is_err, e.is_err});
          check("err_flags", {61'd0, err_flags_o}, {61'd0, e.is_err ? e.flags : 3'b000});
          check("operands", {b_o, a_o}, {e.b, e.a});
          check("op", {61'd0, op_o}, {61'd0, e.op});
        end
      end
    end
    prev_pulse <= valid_o || err_o;
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;
    logic [2:0]  bad_ops[4];
    logic [2:0]  good_ops[4];
    int          sc;
    int          n;
    bad_ops  = '{3'b010, 3'b011, 3'b110, 3'b111};
    good_ops = '{3'b000, 3'b001, 3'b100, 3'b101};

    rst = 1'b1;
    sin = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {23'd0, a_o, b_o[4:0], op_o}, 63'd0);
    check("reset_pulses", {59'd0, b_o[31:28], valid_o, err_o, err_flags_o[0]}, 64'd0);
    rst = 1'b0;
    idle(3);

    // Directed cases.
    send_cmd(32'h0, 32'h0, 3'b000, 4'hB, 8, 0);
    send_cmd(32'h1, 32'hFFFF_FFFF, 3'b100, good_crc(32'h1, 32'hFFFF_FFFF, 3'b100), 8, 0);
    send_cmd(32'h0, 32'h0, 3'b000, 4'hA, 8, 0);
    send_cmd(32'h0, 32'h0, 3'b010, 4'hD, 8, 0);
    send_cmd(32'h1234_5678, 32'h9ABC_DEF0, 3'b001,
             good_crc(32'h1234_5678, 32'h9ABC_DEF0, 3'b001), 7, 1);
    send_cmd(32'h1234_5678, 32'h9ABC_DEF0, 3'b001,
             good_crc(32'h1234_5678, 32'h9ABC_DEF0, 3'b001), 9, 1);
    send_cmd(32'hCAFE_F00D, 32'h0BAD_BEEF, 3'b101,
             good_crc(32'hCAFE_F00D, 32'h0BAD_BEEF, 3'b101), 8, 2);

    // Framing error in packet 3, line high for two cycles, then a good command.
    send_packet(1'b0, 8'h11, 1'b1);
    send_packet(1'b0, 8'h22, 1'b1);
    send_packet(1'b0, 8'h33, 1'b0);
    idle(2);
    send_cmd(32'h0000_00FF, 32'h8000_0000, 3'b100,
             good_crc(32'h0000_00FF, 32'h8000_0000, 3'b100), 8, 0);

    // Reset in the middle of packet 5.
    for (int i = 0; i < 4; i++) send_packet(1'b0, 8'hA5, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    sin = 1'b1;
    cmd_bytes.delete();
    held_a  = 32'd0;
    held_b  = 32'd0;
    held_op = 3'd0;
    @(negedge clk);
    check("midreset_outputs", {a_o, b_o}, 64'd0);
    check("midreset_pulses", {58'd0, op_o, valid_o, err_o, err_flags_o[0]}, 64'd0);
    rst = 1'b0;
    idle(2);
    send_cmd(32'h0102_0304, 32'h0506_0708, 3'b000,
             good_crc(32'h0102_0304, 32'h0506_0708, 3'b000), 8, 0);

    // Randomized commands.
    for (int t = 0; t < 24; t++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = good_ops[$urandom_range(3, 0)];
      sc  = int'($urandom_range(5, 0));
      case (sc)
        0, 1: send_cmd(rb, ra, rop, good_crc(rb, ra, rop), 8, 3);
        2: send_cmd(rb, ra, rop, good_crc(rb, ra, rop) ^ 4'($urandom_range(15, 1)), 8, 2);
        3: begin
          rop = bad_ops[$urandom_range(3, 0)];
          send_cmd(rb, ra, rop, ($urandom_range(1, 0) == 0) ? good_crc(rb, ra, rop)
                                                            : 4'($urandom), 8, 2);
        end
        4: begin
          n = int'($urandom_range(12, 0));
          if (n == 8) n = 10;
          send_cmd(rb, ra, rop, good_crc(rb, ra, rop), n, 1);
        end
        default: begin
          n = int'($urandom_range(7, 0));
          for (int i = 0; i < n; i++) send_packet(1'b0, 8'($urandom), 1'b1);
          send_packet(1'($urandom), 8'($urandom), 1'b0);
          idle(int'($urandom_range(3, 1)));
        end
      endcase
    end

    idle(6);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
